vec_regfile_mp: RTL and testbench

Parametrised vector register file for the vector processor datapath. It holds DEPTH vector registers of LANES × WORD_SIZE bits and provides:
- one lane-masked write port;
- two independent registered read ports with same-cycle write forwarding;
- a per-register busy scoreboard that issue logic uses to track in-flight results.

It sits between the vector decode/issue stage and the lane ALUs.

---
 rtl/vec_regfile_mp.sv | 134 +++++++++++++
 tb/tb_vec_regfile_mp.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_regfile_mp.sv
// Vector register file: DEPTH x (LANES*WORD_SIZE), one lane-masked write port,
// two registered read ports with same-edge write forwarding, busy scoreboard.
// Latency: reads 1 cycle (re -> rvalid/rdata); busy/rsv_err update 1 cycle after the edge.
// Backpressure: none, every port accepts a request on every cycle.
//
// Ports:
//   clk, RESET            rising-edge clock, asynchronous active-high reset
//   we/waddr/wmask/wdata  write port; wmask[i] enables lane i (wdata[i*WORD_SIZE +: WORD_SIZE])
//   re_a/raddr_a          read request port A -> rdata_a/rvalid_a
//   re_b/raddr_b          read request port B -> rdata_b/rvalid_b
//   rsv/rsv_addr          reserve a register (sets busy bit)
//   busy                  bit k = register k has a pending write
//   rsv_err               one-cycle pulse when a reserve hits an already-busy register
module vec_regfile_mp #(
  parameter  int WORD_SIZE = 32,
  parameter  int LANES     = 16,
  parameter  int DEPTH     = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int VW        = LANES * WORD_SIZE
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [LANES-1:0] wmask,
  input  logic [VW-1:0]    wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [VW-1:0]    rdata_a,
  output logic [VW-1:0]    rdata_b,
  output logic             rvalid_a,
  output logic             rvalid_b,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_addr,
  output logic [DEPTH-1:0] busy,
  output logic             rsv_err
);

  // One extra bit so the compare also works when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [VW-1:0]    mem_q [DEPTH];
  logic [VW-1:0]    rdata_a_q, rdata_a_d;
  logic [VW-1:0]    rdata_b_q, rdata_b_d;
  logic             rvalid_a_q, rvalid_b_q;
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             rsv_err_q, rsv_err_d;

  logic w_act;
  logic rsv_act;

  // Out-of-range writes and reserves behave as if never issued.
  assign w_act   = we  && ({1'b0, waddr}    < DEPTH_L);
  assign rsv_act = rsv && ({1'b0, rsv_addr} < DEPTH_L);

  // Per-lane select: masked lanes take nv, the rest keep ov.
  function automatic logic [VW-1:0] lane_merge(input logic [VW-1:0]    ov,
                                               input logic [VW-1:0]    nv,
                                               input logic [LANES-1:0] m);
    logic [VW-1:0] r;
    r = ov;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) r[i*WORD_SIZE +: WORD_SIZE] = nv[i*WORD_SIZE +: WORD_SIZE];
    end
    return r;
  endfunction

  // Read value for one port: zero when out of range, otherwise the stored
  // entry with any same-edge write merged in so read-after-write is seamless.
  function automatic logic [VW-1:0] read_entry(input logic [AW-1:0] addr);
    logic [VW-1:0] r;
    r = '0;
    if ({1'b0, addr} < DEPTH_L) begin
      r = mem_q[addr];
      if (w_act && (addr == waddr)) r = lane_merge(r, wdata, wmask);
    end
    return r;
  endfunction

  always_comb begin
    rdata_a_d = rdata_a_q;
    rdata_b_d = rdata_b_q;
    if (re_a) rdata_a_d = read_entry(raddr_a);
    if (re_b) rdata_b_d = read_entry(raddr_b);
  end

  // Clear on retiring write first, then set on reserve, so a same-edge
  // reserve of the retiring register leaves it busy for the new owner.
  always_comb begin
    busy_d    = busy_q;
    rsv_err_d = 1'b0;
    if (w_act)   busy_d[waddr]    = 1'b0;
    if (rsv_act) busy_d[rsv_addr] = 1'b1;
    if (rsv_act && busy_q[rsv_addr] && !(w_act && (waddr == rsv_addr))) rsv_err_d = 1'b1;
  end

  // Storage array.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else if (w_act) begin
      mem_q[waddr] <= lane_merge(mem_q[waddr], wdata, wmask);
    end
  end

  // Read ports and scoreboard.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      busy_q     <= '0;
      rsv_err_q  <= 1'b0;
    end else begin
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= re_a;
      rvalid_b_q <= re_b;
      busy_q     <= busy_d;
      rsv_err_q  <= rsv_err_d;
    end
  end

  assign rdata_a  = rdata_a_q;
  assign rdata_b  = rdata_b_q;
  assign rvalid_a = rvalid_a_q;
  assign rvalid_b = rvalid_b_q;
  assign busy     = busy_q;
  assign rsv_err  = rsv_err_q;

endmodule

// File: tb/tb_vec_regfile_mp.sv
// Bench for vec_regfile_mp: a default (DEPTH=16) and a DEPTH=12 instance.
// Read expectations are queued at issue time and checked by a monitor process.
// Scoreboard, reset and out-of-range behaviour are checked directly.
module tb_vec_regfile_mp;
  localparam int VW = 16 * 32;

  typedef struct {
    int            cyc;
    logic [VW-1:0] d;
  } rd_t;

  logic clk = 1'b0;
  logic RESET = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // DEPTH=16 instance signals
  logic          we, re_a, re_b, rsv, rvalid_a, rvalid_b, rsv_err;
  logic [3:0]    waddr, raddr_a, raddr_b, rsv_addr;
  logic [15:0]   wmask, busy;
  logic [VW-1:0] wdata, rdata_a, rdata_b;

  // DEPTH=12 instance signals
  logic          we2, re_a2, re_b2, rsv2, rvalid_a2, rvalid_b2, rsv_err2;
  logic [3:0]    waddr2, raddr_a2, raddr_b2, rsv_addr2;
  logic [15:0]   wmask2;
  logic [11:0]   busy2;
  logic [VW-1:0] wdata2, rdata_a2, rdata_b2;

  vec_regfile_mp u_dut (
    .clk(clk), .RESET(RESET), .we(we), .waddr(waddr), .wmask(wmask), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rsv(rsv), .rsv_addr(rsv_addr), .busy(busy), .rsv_err(rsv_err)
  );

  vec_regfile_mp #(.DEPTH(12)) u_dut12 (
    .clk(clk), .RESET(RESET), .we(we2), .waddr(waddr2), .wmask(wmask2), .wdata(wdata2),
    .re_a(re_a2), .raddr_a(raddr_a2), .re_b(re_b2), .raddr_b(raddr_b2),
    .rdata_a(rdata_a2), .rdata_b(rdata_b2), .rvalid_a(rvalid_a2), .rvalid_b(rvalid_b2),
    .rsv(rsv2), .rsv_addr(rsv_addr2), .busy(busy2), .rsv_err(rsv_err2)
  );

  // Expected read responses: 0=A, 1=B, 2=A of DEPTH=12, 3=B of DEPTH=12 (never used).
  rd_t exp_q [4][$];

  function automatic logic [VW-1:0] rep(input logic [31:0] w);
    return {16{w}};
  endfunction

  task automatic expect_rd(input int p, input logic [VW-1:0] d);
    rd_t e;
    e.cyc = cyc + 1;
    e.d   = d;
    exp_q[p].push_back(e);
  endtask

  task automatic port_mon(input int p, input string nm, input logic v, input logic [VW-1:0] d);
    rd_t e;
    if (v) begin
      checks++;
      if (exp_q[p].size() == 0) begin
        errors++;
        $display("FAIL %s unexpected rvalid at cycle %0d data=%h", nm, cyc, d);
      end else begin
        e = exp_q[p].pop_front();
        if (e.cyc != cyc || d !== e.d) begin
          errors++;
          $display("FAIL %s cycle got=%0d want=%0d data got=%h want=%h", nm, cyc, e.cyc, d, e.d);
        end
      end
    end else if (exp_q[p].size() > 0 && exp_q[p][0].cyc <= cyc) begin
      checks++;
      errors++;
      e = exp_q[p].pop_front();
      $display("FAIL %s missing rvalid at cycle %0d want data=%h", nm, cyc, e.d);
    end
  endtask

  always @(negedge clk) begin
    if (!RESET) begin
      port_mon(0, "rd_a",    rvalid_a,  rdata_a);
      port_mon(1, "rd_b",    rvalid_b,  rdata_b);
      port_mon(2, "rd_a_12", rvalid_a2, rdata_a2);
      port_mon(3, "rd_b_12", rvalid_b2, rdata_b2);
    end
  end

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] m, input logic [VW-1:0] d);
    we = 1'b1; waddr = a; wmask = m; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic wr12(input logic [3:0] a, input logic [15:0] m, input logic [VW-1:0] d);
    we2 = 1'b1; waddr2 = a; wmask2 = m; wdata2 = d;
    tick();
    we2 = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int n;
    we = 0; re_a = 0; re_b = 0; rsv = 0; waddr = 0; raddr_a = 0; raddr_b = 0;
    rsv_addr = 0; wmask = 0; wdata = '0;
    we2 = 0; re_a2 = 0; re_b2 = 0; rsv2 = 0; waddr2 = 0; raddr_a2 = 0; raddr_b2 = 0;
    rsv_addr2 = 0; wmask2 = 0; wdata2 = '0;

    // Reset state
    repeat (2) tick();
    chk("reset_rdata_a", rdata_a, '0);
    chk("reset_busy", VW'(busy), '0);
    chk("reset_rvalid", VW'({rvalid_a, rvalid_b, rsv_err}), '0);
    RESET = 1'b0;
    tick();

    // Load entry 4, read it back on both ports
    wr(4'd4, 16'hFFFF, rep(32'hCAFE0004));
    re_a = 1; raddr_a = 4; re_b = 1; raddr_b = 4;
    expect_rd(0, rep(32'hCAFE0004));
    expect_rd(1, rep(32'hCAFE0004));
    tick();
    re_a = 0; re_b = 0;
    // Reserve 9, then reserve 9 again with a read of 4: rsv_err and rvalid all high.
    rsv = 1; rsv_addr = 9;
    tick();
    re_a = 1; raddr_a = 4; re_b = 1; raddr_b = 4;
    tick();
    rsv = 0; re_a = 0; re_b = 0;
    chk("pre_reset_err", VW'({rsv_err, busy}), VW'({1'b1, 16'h0200}));
    #1 RESET = 1'b1;
    #1;
    chk("async_rst_rdata_a", rdata_a, '0);
    chk("async_rst_rdata_b", rdata_b, '0);
    chk("async_rst_flags", VW'({rvalid_a, rvalid_b, rsv_err}), '0);
    chk("async_rst_busy", VW'(busy), '0);
    tick();
    RESET = 1'b0;
    tick();
    re_a = 1; raddr_a = 4;
    expect_rd(0, '0);
    tick();
    re_a = 0;

    // Fill 0..15, then read A=k, B=15-k back to back
    for (int k = 0; k < 16; k++) begin
      w = 32'hFFFFFFF0 + 32'(k);
      wr(4'(k), 16'hFFFF, rep(w));
    end
    for (int k = 0; k < 16; k++) begin
      re_a = 1; raddr_a = 4'(k); re_b = 1; raddr_b = 4'(15 - k);
      w = 32'hFFFFFFF0 + 32'(k);
      expect_rd(0, rep(w));
      w = 32'hFFFFFFFF - 32'(k);
      expect_rd(1, rep(w));
      tick();
    end
    re_a = 0; re_b = 0;
    tick();

    // Partial mask on entry 3
    wr(4'd3, 16'h00FF, rep(32'hA5A5A5A5));
    re_a = 1; raddr_a = 3;
    expect_rd(0, {{8{32'hFFFFFFF3}}, {8{32'hA5A5A5A5}}});
    tick();
    re_a = 0;

    // Same-edge forwarding on entry 5; port B reads 6 unaffected
    we = 1; waddr = 5; wmask = 16'hF0F0; wdata = rep(32'h12345678);
    re_a = 1; raddr_a = 5; re_b = 1; raddr_b = 6;
    expect_rd(0, {{4{32'h12345678}}, {4{32'hFFFFFFF5}}, {4{32'h12345678}}, {4{32'hFFFFFFF5}}});
    expect_rd(1, rep(32'hFFFFFFF6));
    tick();
    we = 0; re_a = 0;
    re_b = 1; raddr_b = 5;
    expect_rd(1, {{4{32'h12345678}}, {4{32'hFFFFFFF5}}, {4{32'h12345678}}, {4{32'hFFFFFFF5}}});
    tick();
    re_b = 0;

    // Scoreboard sequence on register 7
    rsv = 1; rsv_addr = 7;
    tick();
    rsv = 0;
    chk("sb_set", VW'({rsv_err, busy}), VW'({1'b0, 16'h0080}));
    rsv = 1; rsv_addr = 7;
    tick();
    rsv = 0;
    chk("sb_double_rsv", VW'({rsv_err, busy}), VW'({1'b1, 16'h0080}));
    tick();
    chk("sb_err_one_cycle", VW'({rsv_err, busy}), VW'({1'b0, 16'h0080}));
    rsv = 1; rsv_addr = 7; we = 1; waddr = 7; wmask = 16'h0000; wdata = rep(32'hDEADBEEF);
    tick();
    rsv = 0; we = 0;
    chk("sb_set_wins", VW'({rsv_err, busy}), VW'({1'b0, 16'h0080}));
    wr(4'd7, 16'h0000, rep(32'hDEADBEEF));
    chk("sb_clear", VW'({rsv_err, busy}), '0);
    re_a = 1; raddr_a = 7;
    expect_rd(0, rep(32'hFFFFFFF7));
    tick();
    re_a = 0;

    // DEPTH=12 instance: out-of-range write, read and reserve
    for (int k = 0; k < 12; k++) begin
      w = 32'h10000000 + 32'(k);
      wr12(4'(k), 16'hFFFF, rep(w));
    end
    rsv2 = 1; rsv_addr2 = 2;
    tick();
    rsv2 = 0;
    wr12(4'd13, 16'hFFFF, rep(32'hDEADBEEF));
    for (int k = 0; k < 12; k++) begin
      re_a2 = 1; raddr_a2 = 4'(k);
      w = 32'h10000000 + 32'(k);
      expect_rd(2, rep(w));
      tick();
    end
    re_a2 = 1; raddr_a2 = 4'd13;
    expect_rd(2, '0);
    tick();
    re_a2 = 0;
    rsv2 = 1; rsv_addr2 = 4'd13;
    tick();
    rsv2 = 0;
    chk("oor_rsv", VW'({rsv_err2, busy2}), VW'({1'b0, 12'h004}));

    // Drain outstanding expectations
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (exp_q[p].size() != 0) begin
        errors++;
        $display("FAIL drain_port%0d pending=%0d want=0", p, exp_q[p].size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
